// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES-128 inverse cipher, one decryption round per clock.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_valid/in_ready  ciphertext handshake (ready only in IDLE)
//   ciphertext       128-bit input block, byte 0 in [127:120], column-major
//   key_idx          round-key index requested this cycle (decode of state and round counter)
//   round_key        w[key_idx], supplied combinationally by the key store
//   out_valid/out_ready  plaintext handshake
//   plaintext        registered result
//   busy             high while rounds are in progress
module aes_inv_cipher_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   rc_q, rc_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] sr, sb, ark, mc;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse affine transform, then the multiplicative inverse as a^254
    // (a^2 * a^4 * ... * a^128); zero maps to zero naturally.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        logic [7:0] t;
        logic [7:0] r;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        t = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Shared round datapath: row r rotates right by r, then the single
    // InvSubBytes bank feeds both the middle rounds and the final round.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(4*c+r) -: 8] = blk_q[127-8*(4*((c-r+4)%4)+r) -: 8];
        end
        assign mc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    for (genvar b = 0; b < 16; b++) begin : g_sb
        assign sb[127-8*b -: 8] = inv_sbox(sr[127-8*b -: 8]);
    end

    assign ark       = sb ^ round_key;
    assign plaintext = pt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rc_q    <= '0;
            blk_q   <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            blk_q   <= blk_d;
            pt_q    <= pt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        blk_d     = blk_q;
        pt_d      = pt_q;
        key_idx   = 4'd0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                key_idx  = 4'(NR);
                in_ready = 1'b1;
                if (in_valid) begin
                    blk_d   = ciphertext ^ round_key;
                    rc_d    = 4'(NR - 1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                key_idx = rc_q;
                busy    = 1'b1;
                blk_d   = mc;
                state_d = (rc_q == 4'd1) ? FINAL : ROUND;
                rc_d    = (rc_q == 4'd1) ? rc_q : rc_q - 4'd1;
            end
            FINAL: begin
                busy    = 1'b1;
                pt_d    = ark;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                state_d   = out_ready ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
